// File: rtl/vend_pkg.sv
// vend_pkg: shared FSM states, coin codes, coin values and the change unit for the vending controller
package vend_pkg;
  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;
  localparam logic [1:0] COIN_5 = 2'b01;
  localparam logic [1:0] COIN_10 = 2'b10;
  localparam logic [5:0] VAL_5 = 6'd5;
  localparam logic [5:0] VAL_10 = 6'd10;
  localparam logic [5:0] CHG_UNIT = 6'd5;
  function automatic logic [5:0] coin_value(input logic [1:0] code);
    return code == COIN_5 ? VAL_5 : code == COIN_10 ? VAL_10 : 6'd0;
  endfunction
endpackage

// File: rtl/vend_if.sv
// vend_if: vending bus; master drives coin/sel/cancel/disp_ready/chg_ready, slave drives acks, credit, dispense and change requests
interface vend_if;
  logic coin_valid;
  logic [1:0] coin;
  logic sel_valid;
  logic [1:0] sel;
  logic cancel;
  logic disp_ready;
  logic chg_ready;
  logic coin_ack;
  logic coin_rej;
  logic sel_err;
  logic [5:0] credit;
  logic disp_valid;
  logic [1:0] disp_id;
  logic chg_valid;
  logic busy;
  modport master(
    output coin_valid, coin, sel_valid, sel, cancel, disp_ready, chg_ready,
    input coin_ack, coin_rej, sel_err, credit, disp_valid, disp_id, chg_valid, busy
  );
  modport slave(
    input coin_valid, coin, sel_valid, sel, cancel, disp_ready, chg_ready,
    output coin_ack, coin_rej, sel_err, credit, disp_valid, disp_id, chg_valid, busy
  );
endinterface

// File: rtl/vend_price_lut.sv
// vend_price_lut: combinational product id -> price lookup; in sel, out price and ok (id in range)
module vend_price_lut #(
  parameter int PRICE0 = 10,
  parameter int PRICE1 = 15,
  parameter int PRICE2 = 20
) (
  input  logic [1:0] sel,
  output logic [5:0] price,
  output logic       ok
);
  assign price = sel == 2'd0 ? 6'(PRICE0) : sel == 2'd1 ? 6'(PRICE1) : sel == 2'd2 ? 6'(PRICE2) : 6'd0;
  assign ok = sel != 2'd3;
endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: coin-credit vending FSM; ports clk, rst (sync, active-high) and vend_if.slave bus, all outputs registered
module vend_ctrl import vend_pkg::*; #(
  parameter int PRICE0 = 10,
  parameter int PRICE1 = 15,
  parameter int PRICE2 = 20,
  parameter int CREDIT_MAX = 30
) (
  input logic   clk,
  input logic   rst,
  vend_if.slave bus
);
  state_t state, state_n;
  logic [5:0] credit, credit_n, price, cval;
  logic [6:0] sum;
  logic [1:0] disp_id, disp_id_n;
  logic id_ok, coin_ok, sel_ok;
  logic coin_ack, coin_ack_n, coin_rej, coin_rej_n, sel_err, sel_err_n;
  logic disp_valid, disp_valid_n, chg_valid, chg_valid_n, busy, busy_n;
  vend_price_lut #(.PRICE0(PRICE0), .PRICE1(PRICE1), .PRICE2(PRICE2)) lut (
    .sel(bus.sel), .price(price), .ok(id_ok)
  );
  always_comb begin
    cval = coin_value(bus.coin);
    sum = {1'b0, credit} + {1'b0, cval};
    coin_ok = cval != 6'd0 && sum <= 7'(CREDIT_MAX);
    sel_ok = id_ok && credit >= price;
    state_n = state;
    credit_n = credit;
    disp_id_n = disp_id;
    disp_valid_n = disp_valid;
    chg_valid_n = chg_valid;
    coin_ack_n = 1'b0;
    coin_rej_n = bus.coin_valid;
    sel_err_n = bus.sel_valid;
    case (state)
      IDLE: begin
        coin_ack_n = bus.coin_valid && coin_ok;
        coin_rej_n = bus.coin_valid && !coin_ok;
        credit_n = coin_ack_n ? sum[5:0] : credit;
        state_n = coin_ack_n ? CREDIT : IDLE;
      end
      CREDIT: begin
        if (bus.cancel) begin
          state_n = CHANGE;
          chg_valid_n = 1'b1;
        end else if (bus.sel_valid) begin
          sel_err_n = !sel_ok;
          if (sel_ok) begin
            credit_n = credit - price;
            disp_id_n = bus.sel;
            disp_valid_n = 1'b1;
            state_n = VEND;
          end
        end else begin
          coin_ack_n = bus.coin_valid && coin_ok;
          coin_rej_n = bus.coin_valid && !coin_ok;
          credit_n = coin_ack_n ? sum[5:0] : credit;
        end
      end
      VEND: begin
        if (bus.disp_ready) begin
          disp_valid_n = 1'b0;
          chg_valid_n = credit != 6'd0;
          state_n = credit != 6'd0 ? CHANGE : IDLE;
        end
      end
      CHANGE: begin
        credit_n = chg_valid && bus.chg_ready ? credit - CHG_UNIT : credit;
        chg_valid_n = credit_n != 6'd0;
        state_n = credit_n != 6'd0 ? CHANGE : IDLE;
      end
    endcase
    busy_n = state_n == VEND || state_n == CHANGE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      credit <= '0;
      disp_id <= '0;
      disp_valid <= 1'b0;
      chg_valid <= 1'b0;
      coin_ack <= 1'b0;
      coin_rej <= 1'b0;
      sel_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      credit <= credit_n;
      disp_id <= disp_id_n;
      disp_valid <= disp_valid_n;
      chg_valid <= chg_valid_n;
      coin_ack <= coin_ack_n;
      coin_rej <= coin_rej_n;
      sel_err <= sel_err_n;
      busy <= busy_n;
    end
  end
  assign bus.coin_ack = coin_ack;
  assign bus.coin_rej = coin_rej;
  assign bus.sel_err = sel_err;
  assign bus.credit = credit;
  assign bus.disp_valid = disp_valid;
  assign bus.disp_id = disp_id;
  assign bus.chg_valid = chg_valid;
  assign bus.busy = busy;
endmodule
